// File: rtl/edc_scrubber.sv
// Background scrubber for (40,32) SEC-DED RAM: reads each word, checks it with the shared
// encoder/corrector, writes back single-bit fixes and flags uncorrectable words.
module edc_scrubber #(
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic [15:0]   i_interval,
    input  logic          i_host_busy,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [39:0]   o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [39:0]   i_mem_rdata,
    output logic [31:0]   o_enc_data,
    input  logic [7:0]    i_enc_ecc,
    output logic [31:0]   o_cor_data,
    output logic [7:0]    o_cor_syndrome,
    input  logic [31:0]   i_cor_data,
    input  logic          i_cor_detected,
    input  logic          i_cor_uncorrected,
    output logic          o_busy,
    output logic          o_pass_done,
    output logic          o_irq_uncorr,
    output logic [15:0]   o_corr_count,
    output logic [15:0]   o_uncorr_count,
    output logic [AW-1:0] o_last_err_addr
);
    // state | meaning
    // IDLE  | parked, scrub address retained
    // WAIT  | pacing gap of i_interval cycles (skipped when 0)
    // READ  | fetch word, stalled while host owns memory
    // CHECK | re-encode data, register syndrome
    // EVAL  | classify through the corrector
    // WRITE | write back corrected word with fresh check bits
    // NEXT  | advance/wrap address, pass-done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_READ, S_CHECK, S_EVAL, S_WRITE, S_NEXT
    } state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_wait_cnt;
    logic [31:0]   r_data;
    logic [7:0]    r_ecc;
    logic [7:0]    r_syn;
    logic [31:0]   r_fix;
    logic [15:0]   r_corr_cnt;
    logic [15:0]   r_uncorr_cnt;
    logic [AW-1:0] r_last_err;
    logic          r_irq;

    logic w_race, w_last;
    logic w_load_wait, w_latch_rd, w_latch_syn, w_latch_fix;
    logic w_set_last, w_inc_corr, w_inc_uncorr, w_irq, w_adv;

    assign w_race = i_host_we && (i_host_addr == r_addr);
    assign w_last = (r_addr == AW'(DEPTH - 1));

    always_comb begin
        w_next         = r_state;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_wdata    = '0;
        o_enc_data     = '0;
        o_cor_data     = '0;
        o_cor_syndrome = '0;
        o_pass_done    = 1'b0;
        w_load_wait    = 1'b0;
        w_latch_rd     = 1'b0;
        w_latch_syn    = 1'b0;
        w_latch_fix    = 1'b0;
        w_set_last     = 1'b0;
        w_inc_corr     = 1'b0;
        w_inc_uncorr   = 1'b0;
        w_irq          = 1'b0;
        w_adv          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_load_wait = 1'b1;
                    w_next      = (i_interval == 16'd0) ? S_READ : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt <= 16'd1) w_next = S_READ;
            end
            S_READ: begin
                o_mem_req = !i_host_busy;
                if (o_mem_req && i_mem_ack) begin
                    w_latch_rd = 1'b1;
                    w_next     = S_CHECK;
                end
            end
            S_CHECK: begin
                o_enc_data = r_data;
                if (w_race) begin
                    w_next = S_NEXT;
                end else begin
                    w_latch_syn = 1'b1;
                    w_next      = S_EVAL;
                end
            end
            S_EVAL: begin
                o_cor_data     = r_data;
                o_cor_syndrome = r_syn;
                w_next         = S_NEXT;
                // A host write to this word makes our view stale; drop any error handling.
                if (!w_race && i_cor_detected) begin
                    w_set_last = 1'b1;
                    if (i_cor_uncorrected) begin
                        w_inc_uncorr = 1'b1;
                        w_irq        = 1'b1;
                    end else begin
                        w_latch_fix = 1'b1;
                        w_next      = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                o_enc_data  = r_fix;
                o_mem_wdata = {i_enc_ecc, r_fix};
                o_mem_we    = 1'b1;
                if (w_race) begin
                    w_next = S_NEXT;
                end else begin
                    o_mem_req = !i_host_busy;
                    if (o_mem_req && i_mem_ack) begin
                        w_inc_corr = 1'b1;
                        w_next     = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                o_pass_done = w_last;
                w_adv       = 1'b1;
                if (i_enable) begin
                    w_load_wait = 1'b1;
                    w_next      = (i_interval == 16'd0) ? S_READ : S_WAIT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wait_cnt   <= '0;
            r_data       <= '0;
            r_ecc        <= '0;
            r_syn        <= '0;
            r_fix        <= '0;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
            r_last_err   <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_irq   <= w_irq;
            if (w_load_wait)
                r_wait_cnt <= i_interval;
            else if (r_state == S_WAIT && r_wait_cnt != 16'd0)
                r_wait_cnt <= r_wait_cnt - 16'd1;
            if (w_latch_rd) begin
                r_data <= i_mem_rdata[31:0];
                r_ecc  <= i_mem_rdata[39:32];
            end
            if (w_latch_syn) r_syn <= i_enc_ecc ^ r_ecc;
            if (w_latch_fix) r_fix <= i_cor_data;
            if (w_set_last) r_last_err <= r_addr;
            if (w_inc_corr && r_corr_cnt != 16'hFFFF)
                r_corr_cnt <= r_corr_cnt + 16'd1;
            if (w_inc_uncorr && r_uncorr_cnt != 16'hFFFF)
                r_uncorr_cnt <= r_uncorr_cnt + 16'd1;
            if (w_adv) r_addr <= w_last ? '0 : r_addr + 1'b1;
        end
    end

    assign o_mem_addr      = r_addr;
    assign o_busy          = (r_state != S_IDLE);
    assign o_irq_uncorr    = r_irq;
    assign o_corr_count    = r_corr_cnt;
    assign o_uncorr_count  = r_uncorr_cnt;
    assign o_last_err_addr = r_last_err;

endmodule

// File: tb/tb_edc_scrubber.sv
// Bench for edc_scrubber: 4-word memory model, Hsiao-style SEC-DED encoder/corrector model,
// write-back scoreboard, vector table of single-pass scrubs plus multi-cycle corner sequences.
module tb_edc_scrubber;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk, rst, enable;
    logic [15:0]   interval;
    logic          host_busy, host_we;
    logic [AW-1:0] host_addr;
    logic [39:0]   host_wdata;
    logic          mem_req, mem_we, mem_ack, ack_force;
    logic [AW-1:0] mem_addr;
    logic [39:0]   mem_wdata, mem_rdata;
    logic [31:0]   enc_data;
    logic [7:0]    enc_ecc;
    logic [31:0]   cor_in, cor_out;
    logic [7:0]    cor_syn;
    logic          cor_det, cor_unc;
    logic          busy, pass_done, irq;
    logic [15:0]   corr_cnt, uncorr_cnt;
    logic [AW-1:0] last_err;

    logic [39:0] mem [1024];
    logic [39:0] orig [DEPTH];
    int n_cmp, n_fail, rd_cnt, irq_cnt, pass_cnt;

    typedef struct {
        logic [AW-1:0] a;
        logic [39:0]   d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int            addr;
        logic [39:0]   flip;
        logic [15:0]   ival;
        bit            wr;
        logic [15:0]   corr;
        logic [15:0]   unc;
        int            irqs;
        logic [AW-1:0] last;
        int            cyc;
    } vec_t;

    edc_scrubber #(.AW(AW), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_interval(interval),
        .i_host_busy(host_busy), .i_host_we(host_we), .i_host_addr(host_addr),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_enc_data(enc_data), .i_enc_ecc(enc_ecc),
        .o_cor_data(cor_in), .o_cor_syndrome(cor_syn),
        .i_cor_data(cor_out), .i_cor_detected(cor_det), .i_cor_uncorrected(cor_unc),
        .o_busy(busy), .o_pass_done(pass_done), .o_irq_uncorr(irq),
        .o_corr_count(corr_cnt), .o_uncorr_count(uncorr_cnt), .o_last_err_addr(last_err)
    );

    // Column for data bit idx: the idx-th weight-3 byte; check bits use weight-1 columns.
    function automatic logic [7:0] col(input int idx);
        int n;
        logic [7:0] r, b;
        n = 0;
        r = '0;
        for (int v = 0; v < 256; v++) begin
            b = v[7:0];
            if ($countones(b) == 3) begin
                if (n == idx) r = b;
                n++;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] ecc_of(input logic [31:0] d);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 32; i++) if (d[i]) e = e ^ col(i);
        return e;
    endfunction

    assign enc_ecc   = ecc_of(enc_data);
    assign mem_ack   = mem_req | ack_force;
    assign mem_rdata = mem[mem_addr];

    always_comb begin
        cor_out = cor_in;
        cor_det = (cor_syn != 8'h00);
        cor_unc = 1'b0;
        if (cor_det && $countones(cor_syn) != 1) begin
            cor_unc = 1'b1;
            for (int i = 0; i < 32; i++)
                if (col(i) == cor_syn) begin
                    cor_out[i] = ~cor_in[i];
                    cor_unc    = 1'b0;
                end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus monitor and memory model: sample 1ns before the rising edge, commit writes after it.
    initial begin
        logic s_wr, s_hw;
        logic [AW-1:0] s_wa, s_ha;
        logic [39:0] s_wd, s_hd;
        wr_t e;
        forever begin
            @(negedge clk);
            #4;
            s_wr = mem_req && mem_we && mem_ack;
            s_wa = mem_addr;
            s_wd = mem_wdata;
            s_hw = host_busy && host_we;
            s_ha = host_addr;
            s_hd = host_wdata;
            if (mem_req && !mem_we && mem_ack) rd_cnt++;
            if (irq) irq_cnt++;
            if (pass_done) pass_cnt++;
            if (s_wr) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scb_write: unexpected write addr %0d data %h", s_wa, s_wd);
                end else begin
                    e = exp_q.pop_front();
                    if (e.a !== s_wa || e.d !== s_wd) begin
                        n_fail++;
                        $display("FAIL scb_write: actual addr %0d data %h, required addr %0d data %h",
                                 s_wa, s_wd, e.a, e.d);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (s_wr) mem[s_wa] = s_wd;
            if (s_hw) mem[s_ha] = s_hd;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_req"}, 64'(mem_req), 0);
        chk({nm, "_we"}, 64'(mem_we), 0);
        chk({nm, "_addr"}, 64'(mem_addr), 0);
        chk({nm, "_wdata"}, 64'(mem_wdata), 0);
        chk({nm, "_enc"}, 64'(enc_data), 0);
        chk({nm, "_cor_d"}, 64'(cor_in), 0);
        chk({nm, "_cor_s"}, 64'(cor_syn), 0);
        chk({nm, "_busy"}, 64'(busy), 0);
        chk({nm, "_pass"}, 64'(pass_done), 0);
        chk({nm, "_irq"}, 64'(irq), 0);
        chk({nm, "_corr"}, 64'(corr_cnt), 0);
        chk({nm, "_uncorr"}, 64'(uncorr_cnt), 0);
        chk({nm, "_last"}, 64'(last_err), 0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; host_busy = 1'b0; host_we = 1'b0;
        host_addr = '0; ack_force = 1'b0; interval = 16'd0;
        @(negedge clk);
        chk_zero(nm);
        rst = 1'b0;
        exp_q.delete();
        rd_cnt = 0; irq_cnt = 0; pass_cnt = 0;
    endtask

    task automatic fill();
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            orig[i] = {ecc_of(d), d};
            mem[i] = orig[i];
        end
    endtask

    task automatic push_wr(input int a, input logic [39:0] d);
        wr_t w;
        w.a = AW'(a);
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic wait_pass(input string nm, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (pass_done !== 1'b1 && cyc < 400);
        chk({nm, "_pass_seen"}, 64'(pass_done), 1);
    endtask

    task automatic wait_bus(input string nm, input logic want_we);
        int c;
        c = 0;
        while (!(mem_req === 1'b1 && mem_we === want_we && mem_addr == 2) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_found"}, 64'(c < 200), 1);
    endtask

    task automatic hold_host(input string nm);
        host_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("%s_req_%0d", nm, k), 64'(mem_req), 0);
        end
        host_busy = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        int cyc;
        logic [39:0] exp_mem;
        nm = $sformatf("v%0d", idx);
        do_reset({nm, "_rst"});
        fill();
        mem[v.addr] = orig[v.addr] ^ v.flip;
        if (v.wr) push_wr(v.addr, orig[v.addr]);
        exp_mem = v.wr ? orig[v.addr] : (orig[v.addr] ^ v.flip);
        interval = v.ival;
        enable = 1'b1;
        wait_pass(nm, cyc);
        enable = 1'b0;
        chk({nm, "_cycles"}, 64'(cyc), 64'(v.cyc));
        repeat (3) @(negedge clk);
        chk({nm, "_busy"}, 64'(busy), 0);
        chk({nm, "_addr_wrap"}, 64'(mem_addr), 0);
        chk({nm, "_corr"}, 64'(corr_cnt), 64'(v.corr));
        chk({nm, "_uncorr"}, 64'(uncorr_cnt), 64'(v.unc));
        chk({nm, "_last"}, 64'(last_err), 64'(v.last));
        chk({nm, "_irqs"}, 64'(irq_cnt), 64'(v.irqs));
        chk({nm, "_passes"}, 64'(pass_cnt), 1);
        chk({nm, "_reads"}, 64'(rd_cnt), DEPTH);
        chk({nm, "_pending"}, 64'(exp_q.size()), 0);
        chk({nm, "_mem"}, 64'(mem[v.addr]), 64'(exp_mem));
    endtask

    initial begin
        vec_t vecs[5];
        int cyc;
        logic [31:0] hd;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; enable = 1'b0; interval = 16'd0; host_busy = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0; ack_force = 1'b0;

        //          addr flip               ival  wr corr   unc    irq last cycles
        vecs[0] = '{0, 40'h0,             16'd0, 0, 16'd0, 16'd0, 0, 10'd0, 16};
        vecs[1] = '{2, 40'h20,            16'd0, 1, 16'd1, 16'd0, 0, 10'd2, 17};
        vecs[2] = '{1, 40'h3,             16'd0, 0, 16'd0, 16'd1, 1, 10'd1, 16};
        vecs[3] = '{3, 40'h04_0000_0000,  16'd0, 1, 16'd1, 16'd0, 0, 10'd3, 17};
        vecs[4] = '{1, 40'h00_8000_0000,  16'd3, 1, 16'd1, 16'd0, 0, 10'd1, 29};
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Host holds memory during the READ and the WRITE of a correctable word; ack is forced high.
        do_reset("hb_rst");
        fill();
        mem[2] = orig[2] ^ 40'h20;
        push_wr(2, orig[2]);
        ack_force = 1'b1;
        enable = 1'b1;
        wait_bus("hb_rd", 1'b0);
        hold_host("hb_rd");
        wait_bus("hb_wr", 1'b1);
        hold_host("hb_wr");
        wait_pass("hb", cyc);
        enable = 1'b0;
        ack_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("hb_corr", 64'(corr_cnt), 1);
        chk("hb_reads", 64'(rd_cnt), DEPTH);
        chk("hb_pending", 64'(exp_q.size()), 0);
        chk("hb_mem", 64'(mem[2]), 64'(orig[2]));

        // Host writes the erroneous word while it is being evaluated.
        do_reset("race_rst");
        fill();
        mem[2] = orig[2] ^ 40'h20;
        hd = $urandom;
        enable = 1'b1;
        cyc = 0;
        while (cor_syn === 8'h00 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("race_eval_found", 64'(cyc < 200), 1);
        host_busy = 1'b1; host_we = 1'b1; host_addr = 10'd2; host_wdata = {ecc_of(hd), hd};
        @(negedge clk);
        host_busy = 1'b0; host_we = 1'b0;
        wait_pass("race", cyc);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("race_corr", 64'(corr_cnt), 0);
        chk("race_last", 64'(last_err), 0);
        chk("race_pending", 64'(exp_q.size()), 0);
        chk("race_mem", 64'(mem[2]), 64'({ecc_of(hd), hd}));

        // Saturation of the corrected-word counter.
        do_reset("sat_rst");
        force dut.r_corr_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_corr_cnt;
        @(negedge clk);
        chk("sat_preload", 64'(corr_cnt), 64'hFFFE);
        fill();
        mem[0] = orig[0] ^ 40'h20;
        mem[1] = orig[1] ^ 40'h200;
        mem[3] = orig[3] ^ 40'h10_0000;
        push_wr(0, orig[0]);
        push_wr(1, orig[1]);
        push_wr(3, orig[3]);
        enable = 1'b1;
        wait_pass("sat", cyc);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_corr", 64'(corr_cnt), 64'hFFFF);
        chk("sat_last", 64'(last_err), 3);
        chk("sat_pending", 64'(exp_q.size()), 0);

        // Reset while a write-back is on the bus.
        do_reset("mw_rst");
        fill();
        mem[2] = orig[2] ^ 40'h20;
        push_wr(2, orig[2]);
        enable = 1'b1;
        wait_bus("mw_wr", 1'b1);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk_zero("mw");
        rst = 1'b0;
        chk("mw_pending", 64'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
        chk("mw_idle_req", 64'(mem_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
